dm_arbiter: RTL

Data-memory access arbiter for the downsampling processor. Shares the single-port data memory between the CPU datapath (address from the memory address register, 20-bit `dm_addr` space) and the external pixel loader/readout port. Grants one requester at a time, sequences memory enables, and inserts a configurable read latency. Returns read data and a completion pulse to the granted requester.

---
 rtl/dm_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU datapath and
// the external pixel loader/readout port. One access in flight at a time:
// IDLE -> ACCESS (strobe) -> WAIT (read latency) -> DONE (completion pulse).
// Optional feature macro: DM_ARB_ROUND_ROBIN_EN (round-robin on ties; default
// build gives ties to the external port).
module dm_arbiter #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_done,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              last_ext_q, last_ext_d;  // winner of the most recent grant
  logic              cur_ext_q, cur_ext_d;    // owner of the access in flight
  logic              cur_we_q, cur_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              ext_gnt_q, ext_gnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              ext_done_q, ext_done_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              busy_q, busy_d;
  logic              pick_ext;
  logic              sel_we;
  logic              to_done;

  // Arbitration: decide which requester wins when IDLE sees a request.
  always_comb begin
`ifdef DM_ARB_ROUND_ROBIN_EN
    pick_ext = ext_req && (!cpu_req || !last_ext_q);
`else
    pick_ext = ext_req;
`endif
    sel_we = pick_ext ? ext_we : cpu_we;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_ext_d  = last_ext_q;
    cur_ext_d   = cur_ext_q;
    cur_we_d    = cur_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    cpu_gnt_d   = 1'b0;
    ext_gnt_d   = 1'b0;
    cpu_done_d  = 1'b0;
    ext_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    to_done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req || ext_req) begin
          cur_ext_d   = pick_ext;
          last_ext_d  = pick_ext;
          cur_we_d    = sel_we;
          mem_addr_d  = pick_ext ? ext_addr : cpu_addr;
          mem_wdata_d = pick_ext ? ext_wdata : cpu_wdata;
          mem_we_d    = sel_we;
          mem_re_d    = !sel_we;
          cpu_gnt_d   = !pick_ext;
          ext_gnt_d   = pick_ext;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        cnt_d = 3'(WAIT_CYCLES);
        if (WAIT_CYCLES > 0) begin
          state_d = StWait;
        end else begin
          to_done = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          to_done = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Completion pulse and read-data capture happen on the edge entering DONE.
    if (to_done) begin
      state_d    = StDone;
      cpu_done_d = !cur_ext_q;
      ext_done_d = cur_ext_q;
      if (!cur_we_q) begin
        if (cur_ext_q) begin
          ext_rdata_d = mem_rdata;
        end else begin
          cpu_rdata_d = mem_rdata;
        end
      end
    end

    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_ext_q  <= 1'b0;
      cur_ext_q   <= 1'b0;
      cur_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      ext_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      ext_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_ext_q  <= last_ext_d;
      cur_ext_q   <= cur_ext_d;
      cur_we_q    <= cur_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      cpu_gnt_q   <= cpu_gnt_d;
      ext_gnt_q   <= ext_gnt_d;
      cpu_done_q  <= cpu_done_d;
      ext_done_q  <= ext_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ext_gnt   = ext_gnt_q;
  assign ext_done  = ext_done_q;
  assign ext_rdata = ext_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign busy      = busy_q;

endmodule
